dmem_arbiter: RTL and testbench

- Owns port B of the shared dual-port instruction/data RAM and shares it between three requesters:
  - boot copier (ROM→RAM image copy)
  - core datapath (load/store)
  - debug loader
- Sequences the boot phase: exclusive boot access, then asserts `avail` to release the core from reset.
- In run phase, round-robins core and debug, with optional debug burst lock.

---
 rtl/dmem_pkg.sv | 13 +
 rtl/rr_arb2.sv | 57 +++++
 rtl/dmem_arbiter.sv | 126 ++++++++++++
 tb/tb_dmem_arbiter.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and default widths for the data-memory port-B arbiter.
package dmem_pkg;

  localparam int unsigned ADDR_W_DEF     = 10;
  localparam int unsigned DATA_W_DEF     = 32;
  localparam int unsigned BOOT_WORDS_DEF = 256;
  localparam int unsigned LOCK_MAX_DEF   = 8;

  typedef enum logic {BOOT, RUN} arb_state_t;

  typedef enum logic [1:0] {M_NONE, M_BOOT, M_CORE, M_DBG} master_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin (core vs debug) with a bounded debug burst lock.
module rr_arb2
  import dmem_pkg::*;
#(
  parameter int unsigned LOCK_MAX = LOCK_MAX_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  input  logic i_req_core,
  input  logic i_req_dbg,
  input  logic i_lock,
  output logic o_gnt_core_c,
  output logic o_gnt_dbg_c
);

  localparam int unsigned LCNT_W = $clog2(LOCK_MAX + 1);

  logic              r_last_dbg;
  logic [LCNT_W-1:0] r_lock_cnt;
  logic              w_lock_act;

  assign w_lock_act = r_last_dbg & i_lock & (r_lock_cnt < LCNT_W'(LOCK_MAX));

  // Winner selection: lock favours debug, otherwise the one not served last.
  always_comb begin
    o_gnt_core_c = 1'b0;
    o_gnt_dbg_c  = 1'b0;
    if (i_en) begin
      if (i_req_core && i_req_dbg) begin
        if (w_lock_act || !r_last_dbg) o_gnt_dbg_c  = 1'b1;
        else                            o_gnt_core_c = 1'b1;
      end else begin
        o_gnt_core_c = i_req_core;
        o_gnt_dbg_c  = i_req_dbg;
      end
    end
  end

  // Last-winner memory and consecutive locked-debug-grant counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_dbg <= 1'b1;
      r_lock_cnt <= '0;
    end else begin
      if (o_gnt_core_c)     r_last_dbg <= 1'b0;
      else if (o_gnt_dbg_c) r_last_dbg <= 1'b1;

      if (o_gnt_dbg_c && i_lock) begin
        if (r_lock_cnt != LCNT_W'(LOCK_MAX)) r_lock_cnt <= r_lock_cnt + 1'b1;
      end else begin
        r_lock_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Port-B owner of the shared RAM: boot phase sequencing, core/debug
// arbitration, RAM mux and read-valid return pipeline.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W     = ADDR_W_DEF,
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned BOOT_WORDS = BOOT_WORDS_DEF,
  parameter int unsigned LOCK_MAX   = LOCK_MAX_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              boot_req,
  input  logic              boot_we,
  input  logic [ADDR_W-1:0] boot_addr,
  input  logic [DATA_W-1:0] boot_wdata,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  input  logic              dbg_lock,
  output logic              boot_gnt,
  output logic              core_gnt,
  output logic              dbg_gnt,
  output logic              boot_rvalid,
  output logic              core_rvalid,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              avail
);

  localparam int unsigned CNT_W = $clog2(BOOT_WORDS + 1);

  arb_state_t       r_state;
  logic [CNT_W-1:0] r_boot_cnt;
  logic             r_boot_rv;
  logic             r_core_rv;
  logic             r_dbg_rv;
  logic             w_run;
  logic             w_core_win;
  logic             w_dbg_win;
  master_t          w_gnt;

  assign w_run = (r_state == RUN);

  rr_arb2 #(
    .LOCK_MAX (LOCK_MAX)
  ) u_rr (
    .clk          (clk),
    .rst          (rst),
    .i_en         (w_run),
    .i_req_core   (core_req),
    .i_req_dbg    (dbg_req),
    .i_lock       (dbg_lock),
    .o_gnt_core_c (w_core_win),
    .o_gnt_dbg_c  (w_dbg_win)
  );

  // Single owner per cycle: boot only in BOOT, core/debug only in RUN.
  always_comb begin
    w_gnt = M_NONE;
    if (!w_run) begin
      if (boot_req) w_gnt = M_BOOT;
    end else if (w_core_win) begin
      w_gnt = M_CORE;
    end else if (w_dbg_win) begin
      w_gnt = M_DBG;
    end
  end

  assign boot_gnt = (w_gnt == M_BOOT);
  assign core_gnt = (w_gnt == M_CORE);
  assign dbg_gnt  = (w_gnt == M_DBG);

  // RAM port-B mux driven by the granted master; zeros when idle.
  always_comb begin
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    unique case (w_gnt)
      M_BOOT: begin ram_we = boot_we; ram_addr = boot_addr; ram_wdata = boot_wdata; end
      M_CORE: begin ram_we = core_we; ram_addr = core_addr; ram_wdata = core_wdata; end
      M_DBG:  begin ram_we = dbg_we;  ram_addr = dbg_addr;  ram_wdata = dbg_wdata;  end
      default: ;
    endcase
  end

  // Boot phase FSM: count granted boot writes, switch to RUN on the last one.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= BOOT;
      r_boot_cnt <= '0;
    end else if (r_state == BOOT && boot_req && boot_we) begin
      if (r_boot_cnt == CNT_W'(BOOT_WORDS - 1)) r_state <= RUN;
      if (r_boot_cnt != CNT_W'(BOOT_WORDS))     r_boot_cnt <= r_boot_cnt + 1'b1;
    end
  end

  // Read-valid return: owner of a granted read sees rvalid one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_boot_rv <= 1'b0;
      r_core_rv <= 1'b0;
      r_dbg_rv  <= 1'b0;
    end else begin
      r_boot_rv <= boot_gnt & ~boot_we;
      r_core_rv <= core_gnt & ~core_we;
      r_dbg_rv  <= dbg_gnt  & ~dbg_we;
    end
  end

  assign boot_rvalid = r_boot_rv;
  assign core_rvalid = r_core_rv;
  assign dbg_rvalid  = r_dbg_rv;
  assign rdata       = ram_rdata;
  assign avail       = w_run;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter with a behavioural port-B RAM.
module tb_dmem_arbiter;

  localparam int unsigned AW = 10;
  localparam int unsigned DW = 32;
  localparam logic [31:0] PAT = 32'hA5A5_0000;

  logic          clk = 1'b0;
  logic          rst;
  logic          boot_req, boot_we, core_req, core_we, dbg_req, dbg_we, dbg_lock;
  logic [AW-1:0] boot_addr, core_addr, dbg_addr;
  logic [DW-1:0] boot_wdata, core_wdata, dbg_wdata;
  logic          boot_gnt, core_gnt, dbg_gnt;
  logic          boot_rvalid, core_rvalid, dbg_rvalid;
  logic [DW-1:0] rdata;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;
  logic          avail;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    int          cyc;
    logic [31:0] data;
  } exp_t;

  exp_t  q [3][$];
  string names [3] = '{"boot", "core", "dbg"};

  always #5 clk = ~clk;

  dmem_arbiter dut (
    .clk(clk), .rst(rst),
    .boot_req(boot_req), .boot_we(boot_we), .boot_addr(boot_addr), .boot_wdata(boot_wdata),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_lock(dbg_lock),
    .boot_gnt(boot_gnt), .core_gnt(core_gnt), .dbg_gnt(dbg_gnt),
    .boot_rvalid(boot_rvalid), .core_rvalid(core_rvalid), .dbg_rvalid(dbg_rvalid),
    .rdata(rdata), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .avail(avail)
  );

  // Synchronous RAM, read data one cycle after address.
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: compare each rvalid against the expected-response queues.
  always @(negedge clk) begin
    logic rv [3];
    rv[0] = boot_rvalid;
    rv[1] = core_rvalid;
    rv[2] = dbg_rvalid;
    for (int m = 0; m < 3; m++) begin
      if (q[m].size() > 0 && q[m][0].cyc == cyc) begin
        chk({names[m], "_rvalid"}, 32'(rv[m]), 32'd1);
        if (rv[m]) chk({names[m], "_rdata"}, rdata, q[m][0].data);
        void'(q[m].pop_front());
      end else if (rv[m]) begin
        chk({names[m], "_spurious_rvalid"}, 32'(rv[m]), 32'd0);
      end
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    boot_req = 0; boot_we = 0; boot_addr = '0; boot_wdata = '0;
    core_req = 0; core_we = 0; core_addr = '0; core_wdata = '0;
    dbg_req  = 0; dbg_we  = 0; dbg_addr  = '0; dbg_wdata  = '0;
    dbg_lock = 0;
  endtask

  task automatic boot_wr(input int i);
    boot_req   = 1;
    boot_we    = 1;
    boot_addr  = AW'(i);
    boot_wdata = 32'(i) ^ PAT;
  endtask

  // Both core (addr 5) and debug (addr 7) reading; push expected owner.
  task automatic both_read_cycle(input string tag, input bit exp_core);
    core_req = 1; core_we = 0; core_addr = AW'(5);
    dbg_req  = 1; dbg_we  = 0; dbg_addr  = AW'(7);
    #3;
    chk({tag, "_core_gnt"}, 32'(core_gnt), 32'(exp_core));
    chk({tag, "_dbg_gnt"},  32'(dbg_gnt),  32'(!exp_core));
    if (exp_core) q[1].push_back('{cyc + 1, 32'd5 ^ PAT});
    else          q[2].push_back('{cyc + 1, 32'd7 ^ PAT});
    nxt();
  endtask

  initial begin
    rst = 1;
    idle();
    repeat (2) @(posedge clk);
    #1 rst = 0;
    #3;
    chk("rst_boot_gnt", 32'(boot_gnt), 0);
    chk("rst_core_gnt", 32'(core_gnt), 0);
    chk("rst_dbg_gnt",  32'(dbg_gnt),  0);
    chk("rst_ram_we",   32'(ram_we),   0);
    chk("rst_ram_addr", 32'(ram_addr), 0);
    chk("rst_ram_wdata", ram_wdata,    0);
    chk("rst_avail",    32'(avail),    0);
    chk("rst_rvalids",  32'({boot_rvalid, core_rvalid, dbg_rvalid}), 0);
    nxt();

    // Partial boot, then reset on write 100.
    for (int i = 0; i < 100; i++) begin
      boot_wr(i);
      nxt();
    end
    boot_wr(100);
    rst = 1;
    nxt();
    rst = 0;

    // Full boot with core/debug requesting throughout.
    for (int i = 0; i < 256; i++) begin
      boot_wr(i);
      core_req = 1; core_we = 0; core_addr = AW'(1);
      dbg_req  = 1; dbg_we  = 0; dbg_addr  = AW'(2);
      #3;
      chk("boot_gnt", 32'(boot_gnt), 1);
      chk("boot_core_gnt", 32'(core_gnt), 0);
      chk("boot_dbg_gnt",  32'(dbg_gnt),  0);
      chk("boot_ram_addr", 32'(ram_addr), 32'(i));
      chk("boot_ram_we",   32'(ram_we),   1);
      chk("boot_avail",    32'(avail),    0);
      nxt();
    end
    idle();
    #3;
    chk("avail_after_boot", 32'(avail), 1);
    chk("idle_gnts", 32'({boot_gnt, core_gnt, dbg_gnt}), 0);
    for (int i = 0; i < 256; i++) chk("boot_mem", mem[i], 32'(i) ^ PAT);
    nxt();

    // Plain round-robin: core wins first tie.
    for (int k = 0; k < 6; k++) both_read_cycle("rr", (k % 2) == 0);
    idle();
    nxt();
    nxt();

    // Debug burst lock after a debug win.
    for (int k = 0; k < 20; k++) begin
      dbg_lock = 1;
      both_read_cycle("lock", (k == 8) || (k == 17));
    end
    idle();
    nxt();
    nxt();

    // Boot requests ignored once running.
    for (int k = 0; k < 3; k++) begin
      boot_req = 1; boot_we = 1; boot_addr = AW'(3); boot_wdata = '0;
      #3;
      chk("run_boot_gnt", 32'(boot_gnt), 0);
      chk("run_boot_ram_we", 32'(ram_we), 0);
      nxt();
    end
    idle();
    nxt();
    #3;
    chk("run_boot_mem3", mem[3], 32'd3 ^ PAT);
    nxt();

    // Reset in the same cycle as a granted core read drops it.
    core_req = 1; core_we = 0; core_addr = AW'(9);
    rst = 1;
    #3;
    chk("rst_rd_core_gnt", 32'(core_gnt), 1);
    nxt();
    rst = 0;
    core_req = 1;
    #3;
    chk("rst_rd_core_rvalid", 32'(core_rvalid), 0);
    chk("rst_rd_avail", 32'(avail), 0);
    chk("rst_boot_core_gnt", 32'(core_gnt), 0);
    nxt();
    idle();
    nxt();
    nxt();

    chk("scoreboard_empty", 32'(q[0].size() + q[1].size() + q[2].size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
